// File: rtl/id_ex_alu_feed.sv
// id_ex_alu_feed: ID/EX register with MIPS-to-ALU decode, operand select and EX/MEM, MEM/WB forwarding.
module id_ex_alu_feed #(
    parameter int N = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             stall,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [31:0]      instruction,
    input  logic [N-1:0]     rs_data,
    input  logic [N-1:0]     rt_data,
    input  logic             ex_mem_reg_write,
    input  logic [4:0]       ex_mem_dest,
    input  logic [N-1:0]     ex_mem_result,
    input  logic             mem_wb_reg_write,
    input  logic [4:0]       mem_wb_dest,
    input  logic [N-1:0]     mem_wb_result,
    output logic [3:0]       alu_op_code,
    output logic [N-1:0]     operand1,
    output logic [N-1:0]     operand2,
    output logic [N-1:0]     store_data,
    output logic [4:0]       dest_reg,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic             branch_eq,
    output logic             branch_ne,
    output logic             valid,
    output logic             illegal,
    output logic [CNT_W-1:0] retired_count
);
    localparam logic [3:0] SLL = 4'd0, SRL = 4'd1, SRA = 4'd2, ADD = 4'd3, SUB = 4'd4;
    localparam logic [3:0] AND = 4'd5, OR = 4'd6, XOR = 4'd7, NOR = 4'd8, SLT = 4'd9;
    logic [5:0] opc, funct;
    logic [4:0] rs, rt, rd;
    logic [N-1:0] shamt_ext, imm_sext, imm_zext;
    logic d_ok, d_op1_rs, d_op2_rt, d_rw, d_mr, d_mw, d_m2r, d_beq, d_bne;
    logic [3:0] d_op;
    logic [4:0] d_dest;
    logic [N-1:0] d_c1, d_c2;
    logic take, bad;
    logic op1_rs_r, op2_rt_r;
    logic [4:0] rs_idx_r, rt_idx_r;
    logic [N-1:0] rs_val_r, rt_val_r, c1_r, c2_r, fwd_rs, fwd_rt;
    assign opc = instruction[31:26];
    assign rs = instruction[25:21];
    assign rt = instruction[20:16];
    assign rd = instruction[15:11];
    assign funct = instruction[5:0];
    assign shamt_ext = {{(N-5){1'b0}}, instruction[10:6]};
    assign imm_sext = {{(N-16){instruction[15]}}, instruction[15:0]};
    assign imm_zext = {{(N-16){1'b0}}, instruction[15:0]};
    always_comb begin
        d_ok = 1'b1;
        d_op = ADD;
        d_op1_rs = 1'b1;
        d_op2_rt = 1'b1;
        d_c1 = '0;
        d_c2 = '0;
        d_dest = rt;
        d_rw = 1'b1;
        d_mr = 1'b0;
        d_mw = 1'b0;
        d_m2r = 1'b0;
        d_beq = 1'b0;
        d_bne = 1'b0;
        case (opc)
            6'h00: begin
                d_dest = rd;
                case (funct)
                    6'h00: begin d_op = SLL; d_op1_rs = 1'b0; d_c1 = shamt_ext; end
                    6'h02: begin d_op = SRL; d_op1_rs = 1'b0; d_c1 = shamt_ext; end
                    6'h03: begin d_op = SRA; d_op1_rs = 1'b0; d_c1 = shamt_ext; end
                    6'h04: d_op = SLL;
                    6'h06: d_op = SRL;
                    6'h07: d_op = SRA;
                    6'h20, 6'h21: d_op = ADD;
                    6'h22, 6'h23: d_op = SUB;
                    6'h24: d_op = AND;
                    6'h25: d_op = OR;
                    6'h26: d_op = XOR;
                    6'h27: d_op = NOR;
                    6'h2A: d_op = SLT;
                    6'h08: d_rw = 1'b0;
                    default: d_ok = 1'b0;
                endcase
            end
            6'h08, 6'h09: begin d_op2_rt = 1'b0; d_c2 = imm_sext; end
            6'h0A: begin d_op = SLT; d_op2_rt = 1'b0; d_c2 = imm_sext; end
            6'h0C: begin d_op = AND; d_op2_rt = 1'b0; d_c2 = imm_zext; end
            6'h0D: begin d_op = OR; d_op2_rt = 1'b0; d_c2 = imm_zext; end
            6'h0E: begin d_op = XOR; d_op2_rt = 1'b0; d_c2 = imm_zext; end
            6'h0F: begin d_op = SLL; d_op1_rs = 1'b0; d_c1 = N'(16); d_op2_rt = 1'b0; d_c2 = imm_zext; end
            6'h23: begin d_op2_rt = 1'b0; d_c2 = imm_sext; d_mr = 1'b1; d_m2r = 1'b1; end
            6'h2B: begin d_op2_rt = 1'b0; d_c2 = imm_sext; d_mw = 1'b1; d_rw = 1'b0; end
            6'h04: begin d_op = SUB; d_beq = 1'b1; d_rw = 1'b0; end
            6'h05: begin d_op = SUB; d_bne = 1'b1; d_rw = 1'b0; end
            default: d_ok = 1'b0;
        endcase
        d_rw = d_rw && (d_dest != 5'd0);
    end
    // An unrecognised instruction still loads a bubble, only flagged as illegal
    assign take = !flush && !stall && id_valid && d_ok;
    assign bad = !flush && !stall && id_valid && !d_ok;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            illegal <= 1'b0;
            alu_op_code <= ADD;
            op1_rs_r <= 1'b0;
            op2_rt_r <= 1'b0;
            c1_r <= '0;
            c2_r <= '0;
            rs_idx_r <= '0;
            rt_idx_r <= '0;
            rs_val_r <= '0;
            rt_val_r <= '0;
            dest_reg <= '0;
            reg_write <= 1'b0;
            mem_read <= 1'b0;
            mem_write <= 1'b0;
            mem_to_reg <= 1'b0;
            branch_eq <= 1'b0;
            branch_ne <= 1'b0;
            retired_count <= '0;
        end else if (enable) begin
            valid <= take;
            illegal <= bad;
            alu_op_code <= take ? d_op : ADD;
            op1_rs_r <= take && d_op1_rs;
            op2_rt_r <= take && d_op2_rt;
            c1_r <= take ? d_c1 : '0;
            c2_r <= take ? d_c2 : '0;
            rs_idx_r <= take ? rs : '0;
            rt_idx_r <= take ? rt : '0;
            rs_val_r <= take ? rs_data : '0;
            rt_val_r <= take ? rt_data : '0;
            dest_reg <= take ? d_dest : '0;
            reg_write <= take && d_rw;
            mem_read <= take && d_mr;
            mem_write <= take && d_mw;
            mem_to_reg <= take && d_m2r;
            branch_eq <= take && d_beq;
            branch_ne <= take && d_bne;
            retired_count <= retired_count + CNT_W'(take);
        end
    end
    // Register 0 never forwards, so bubbles (indices cleared) always read zero data
    assign fwd_rs = (ex_mem_reg_write && ex_mem_dest != 5'd0 && ex_mem_dest == rs_idx_r) ? ex_mem_result :
                    (mem_wb_reg_write && mem_wb_dest != 5'd0 && mem_wb_dest == rs_idx_r) ? mem_wb_result : rs_val_r;
    assign fwd_rt = (ex_mem_reg_write && ex_mem_dest != 5'd0 && ex_mem_dest == rt_idx_r) ? ex_mem_result :
                    (mem_wb_reg_write && mem_wb_dest != 5'd0 && mem_wb_dest == rt_idx_r) ? mem_wb_result : rt_val_r;
    assign operand1 = op1_rs_r ? fwd_rs : c1_r;
    assign operand2 = op2_rt_r ? fwd_rt : c2_r;
    assign store_data = fwd_rt;
endmodule

// File: tb/tb_id_ex_alu_feed.sv
// tb_id_ex_alu_feed: directed scoreboard bench for the ID/EX ALU feed register.
module tb_id_ex_alu_feed;
    logic clk = 1'b0, reset = 1'b0, enable = 1'b1, stall = 1'b0, flush = 1'b0, id_valid = 1'b0;
    logic [31:0] instruction = '0, rs_data = '0, rt_data = '0;
    logic ex_mem_reg_write = 1'b0, mem_wb_reg_write = 1'b0;
    logic [4:0] ex_mem_dest = '0, mem_wb_dest = '0;
    logic [31:0] ex_mem_result = '0, mem_wb_result = '0;
    logic [3:0] alu_op_code;
    logic [31:0] operand1, operand2, store_data, retired_count;
    logic [4:0] dest_reg;
    logic reg_write, mem_read, mem_write, mem_to_reg, branch_eq, branch_ne, valid, illegal;
    int total = 0, bad = 0;

    typedef struct {
        logic [3:0] op;
        logic [31:0] o1, o2, sd, cnt;
        logic [4:0] d;
        logic rw, mr, mw, v, il;
    } exp_t;
    exp_t sb[$];

    id_ex_alu_feed #(.N(32), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .enable(enable), .stall(stall), .flush(flush),
        .id_valid(id_valid), .instruction(instruction), .rs_data(rs_data), .rt_data(rt_data),
        .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_dest(ex_mem_dest), .ex_mem_result(ex_mem_result),
        .mem_wb_reg_write(mem_wb_reg_write), .mem_wb_dest(mem_wb_dest), .mem_wb_result(mem_wb_result),
        .alu_op_code(alu_op_code), .operand1(operand1), .operand2(operand2), .store_data(store_data),
        .dest_reg(dest_reg), .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .branch_eq(branch_eq), .branch_ne(branch_ne), .valid(valid),
        .illegal(illegal), .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rtype(logic [4:0] s, logic [4:0] t, logic [4:0] d, logic [4:0] sh, logic [5:0] fn);
        return {6'h00, s, t, d, sh, fn};
    endfunction

    function automatic logic [31:0] itype(logic [5:0] op, logic [4:0] s, logic [4:0] t, logic [15:0] imm);
        return {op, s, t, imm};
    endfunction

    function automatic exp_t mk(logic [3:0] op, logic [31:0] o1, logic [31:0] o2, logic [31:0] sd, logic [4:0] d,
                                logic rw, logic mr, logic mw, logic v, logic il, logic [31:0] cnt);
        exp_t e;
        e.op = op; e.o1 = o1; e.o2 = o2; e.sd = sd; e.d = d;
        e.rw = rw; e.mr = mr; e.mw = mw; e.v = v; e.il = il; e.cnt = cnt;
        return e;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(string tag, exp_t e);
        chk({tag, ".op"}, {28'd0, alu_op_code}, {28'd0, e.op});
        chk({tag, ".op1"}, operand1, e.o1);
        chk({tag, ".op2"}, operand2, e.o2);
        chk({tag, ".sd"}, store_data, e.sd);
        chk({tag, ".dest"}, {27'd0, dest_reg}, {27'd0, e.d});
        chk({tag, ".rw"}, {31'd0, reg_write}, {31'd0, e.rw});
        chk({tag, ".mr"}, {31'd0, mem_read}, {31'd0, e.mr});
        chk({tag, ".mw"}, {31'd0, mem_write}, {31'd0, e.mw});
        chk({tag, ".valid"}, {31'd0, valid}, {31'd0, e.v});
        chk({tag, ".illegal"}, {31'd0, illegal}, {31'd0, e.il});
        chk({tag, ".cnt"}, retired_count, e.cnt);
    endtask

    task automatic drive(logic [31:0] ins, logic [31:0] rs, logic [31:0] rt, logic iv, exp_t e);
        instruction = ins;
        rs_data = rs;
        rt_data = rt;
        id_valid = iv;
        sb.push_back(e);
    endtask

    task automatic step(string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
        end else begin
            e = sb.pop_front();
            check_outs(tag, e);
        end
    endtask

    initial begin
        #1 reset = 1'b1;
        #1 check_outs("reset", mk(4'd3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1 reset = 1'b0;

        drive(rtype(1, 2, 3, 0, 6'h20), 32'd5, 32'd7, 1'b1, mk(4'd3, 5, 7, 7, 3, 1, 0, 0, 1, 0, 1));
        step("add");
        drive(rtype(0, 2, 4, 3, 6'h00), 32'd0, 32'd1, 1'b1, mk(4'd0, 3, 1, 1, 4, 1, 0, 0, 1, 0, 2));
        step("sll");
        drive(itype(6'h0F, 0, 5, 16'h1234), 32'd9, 32'd0, 1'b1, mk(4'd0, 16, 32'h1234, 0, 5, 1, 0, 0, 1, 0, 3));
        step("lui");
        drive(itype(6'h08, 1, 6, 16'hFFFF), 32'd0, 32'd0, 1'b1, mk(4'd3, 0, 32'hFFFF_FFFF, 0, 6, 1, 0, 0, 1, 0, 4));
        step("addi");
        drive(itype(6'h0D, 1, 8, 16'hFFFF), 32'h10, 32'd0, 1'b1, mk(4'd6, 32'h10, 32'h0000_FFFF, 0, 8, 1, 0, 0, 1, 0, 5));
        step("ori");
        drive(rtype(1, 2, 7, 0, 6'h22), 32'h11, 32'h22, 1'b1, mk(4'd4, 32'h11, 32'h22, 32'h22, 7, 1, 0, 0, 1, 0, 6));
        step("sub");

        id_valid = 1'b0;
        ex_mem_reg_write = 1'b1; ex_mem_dest = 5'd1; ex_mem_result = 32'hAA;
        mem_wb_reg_write = 1'b1; mem_wb_dest = 5'd1; mem_wb_result = 32'hBB;
        #1 chk("fwd_exmem", operand1, 32'hAA);
        ex_mem_reg_write = 1'b0;
        #1 chk("fwd_memwb", operand1, 32'hBB);
        mem_wb_dest = 5'd2;
        #1 chk("fwd_rt_op2", operand2, 32'hBB);
        chk("fwd_rt_sd", store_data, 32'hBB);
        chk("fwd_rs_none", operand1, 32'h11);
        ex_mem_reg_write = 1'b1; ex_mem_dest = 5'd0; mem_wb_dest = 5'd0;
        #1 chk("fwd_dest0_op1", operand1, 32'h11);
        chk("fwd_dest0_op2", operand2, 32'h22);
        ex_mem_reg_write = 1'b0; mem_wb_reg_write = 1'b0;

        stall = 1'b1; flush = 1'b1;
        drive(itype(6'h23, 1, 9, 16'h0004), 32'h100, 32'd0, 1'b1, mk(4'd3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6));
        step("stall_flush");
        stall = 1'b0; flush = 1'b0;
        drive(itype(6'h23, 1, 9, 16'h0004), 32'h100, 32'd0, 1'b1, mk(4'd3, 32'h100, 4, 0, 9, 1, 1, 0, 1, 0, 7));
        step("lw");
        chk("lw.m2r", {31'd0, mem_to_reg}, 32'd1);
        enable = 1'b0;
        drive(rtype(1, 2, 3, 0, 6'h20), 32'd5, 32'd7, 1'b1, mk(4'd3, 32'h100, 4, 0, 9, 1, 1, 0, 1, 0, 7));
        step("frozen");
        enable = 1'b1;
        drive(itype(6'h3F, 1, 2, 16'h0000), 32'd5, 32'd7, 1'b1, mk(4'd3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7));
        step("illegal");
        drive(rtype(1, 2, 3, 0, 6'h20), 32'd5, 32'd7, 1'b0, mk(4'd3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7));
        step("id_invalid");
        drive(rtype(1, 2, 0, 0, 6'h20), 32'd1, 32'd2, 1'b1, mk(4'd3, 1, 2, 2, 0, 0, 0, 0, 1, 0, 8));
        step("add_r0");
        drive(itype(6'h05, 3, 4, 16'h0010), 32'd9, 32'd8, 1'b1, mk(4'd4, 9, 8, 8, 4, 0, 0, 0, 1, 0, 9));
        step("bne");
        chk("bne.flag", {31'd0, branch_ne}, 32'd1);
        drive(itype(6'h2B, 1, 2, 16'h0008), 32'h200, 32'h55, 1'b1, mk(4'd3, 32'h200, 8, 32'h55, 2, 0, 0, 1, 1, 0, 10));
        step("sw");

        #2 reset = 1'b1;
        #1 check_outs("async_reset", mk(4'd3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
